// File: rtl/seg7_pkg.sv
// Shared 7-segment symbol set, symbol index type and sequencer state encoding.
package seg7_pkg;

    typedef logic [5:0] sym_t;

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    // Segment patterns, bits [6:0] = g..a
    localparam logic [6:0] NUM_0       = 7'h3f;
    localparam logic [6:0] NUM_1       = 7'h06;
    localparam logic [6:0] NUM_2       = 7'h5b;
    localparam logic [6:0] NUM_3       = 7'h4f;
    localparam logic [6:0] NUM_4       = 7'h66;
    localparam logic [6:0] NUM_5       = 7'h6d;
    localparam logic [6:0] NUM_6       = 7'h7d;
    localparam logic [6:0] NUM_7       = 7'h07;
    localparam logic [6:0] NUM_8       = 7'h7f;
    localparam logic [6:0] NUM_9       = 7'h6f;
    localparam logic [6:0] LETRA_A     = 7'h77;
    localparam logic [6:0] LETRA_B     = 7'h7c;
    localparam logic [6:0] LETRA_C     = 7'h39;
    localparam logic [6:0] LETRA_C_MIN = 7'h58;
    localparam logic [6:0] LETRA_D     = 7'h5e;
    localparam logic [6:0] LETRA_E     = 7'h79;
    localparam logic [6:0] LETRA_F     = 7'h71;
    localparam logic [6:0] LETRA_G     = 7'h6f;
    localparam logic [6:0] LETRA_H     = 7'h76;
    localparam logic [6:0] LETRA_H_MIN = 7'h74;
    localparam logic [6:0] LETRA_I_MIN = 7'h10;
    localparam logic [6:0] LETRA_I     = 7'h06;
    localparam logic [6:0] LETRA_J     = 7'h1e;
    localparam logic [6:0] LETRA_L     = 7'h38;
    localparam logic [6:0] LETRA_N     = 7'h54;
    localparam logic [6:0] LETRA_O     = 7'h3f;
    localparam logic [6:0] LETRA_O_MIN = 7'h5c;
    localparam logic [6:0] LETRA_P     = 7'h73;
    localparam logic [6:0] LETRA_Q     = 7'h67;
    localparam logic [6:0] LETRA_R     = 7'h50;
    localparam logic [6:0] LETRA_S     = 7'h6d;
    localparam logic [6:0] LETRA_T     = 7'h78;
    localparam logic [6:0] LETRA_U     = 7'h3e;
    localparam logic [6:0] LETRA_V     = 7'h1c;
    localparam logic [6:0] LETRA_Y     = 7'h6e;
    localparam logic [6:0] GRAU        = 7'h63;
    localparam logic [6:0] BLANK       = 7'h00;

endpackage

// File: rtl/seg7_symbol_decoder.sv
// Combinational symbol-index to 7-segment pattern decoder (hex digits, letters, degree).
module seg7_symbol_decoder
    import seg7_pkg::*;
(
    input  sym_t       i_sym,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = BLANK;
        case (i_sym)
            6'd0:  o_seg = NUM_0;
            6'd1:  o_seg = NUM_1;
            6'd2:  o_seg = NUM_2;
            6'd3:  o_seg = NUM_3;
            6'd4:  o_seg = NUM_4;
            6'd5:  o_seg = NUM_5;
            6'd6:  o_seg = NUM_6;
            6'd7:  o_seg = NUM_7;
            6'd8:  o_seg = NUM_8;
            6'd9:  o_seg = NUM_9;
            6'd10: o_seg = LETRA_A;
            6'd11: o_seg = LETRA_B;
            6'd12: o_seg = LETRA_C;
            6'd13: o_seg = LETRA_D;
            6'd14: o_seg = LETRA_E;
            6'd15: o_seg = LETRA_F;
            6'd16: o_seg = LETRA_A;
            6'd17: o_seg = LETRA_B;
            6'd18: o_seg = LETRA_C;
            6'd19: o_seg = LETRA_C_MIN;
            6'd20: o_seg = LETRA_D;
            6'd21: o_seg = LETRA_E;
            6'd22: o_seg = LETRA_F;
            6'd23: o_seg = LETRA_G;
            6'd24: o_seg = LETRA_H;
            6'd25: o_seg = LETRA_H_MIN;
            6'd26: o_seg = LETRA_I_MIN;
            6'd27: o_seg = LETRA_I;
            6'd28: o_seg = LETRA_J;
            6'd29: o_seg = LETRA_L;
            6'd30: o_seg = LETRA_N;
            6'd31: o_seg = LETRA_O;
            6'd32: o_seg = LETRA_O_MIN;
            6'd33: o_seg = LETRA_P;
            6'd34: o_seg = LETRA_Q;
            6'd35: o_seg = LETRA_R;
            6'd36: o_seg = LETRA_S;
            6'd37: o_seg = LETRA_T;
            6'd38: o_seg = LETRA_U;
            6'd39: o_seg = LETRA_V;
            6'd40: o_seg = LETRA_Y;
            6'd41: o_seg = GRAU;
            default: o_seg = BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_msg_sequencer.sv
// Timed start/stop scheduler showing a latched message of up to MAX_LEN symbols on one display.
// Optional SEG7_MSG_DP_EN: lights the decimal point while the last symbol is shown.
module seg7_msg_sequencer
    import seg7_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 25000000,
    parameter int unsigned GAP_TICKS = 1,
    parameter int unsigned MAX_LEN   = 8,
    parameter int unsigned SYM_W     = 6
) (
    input  logic                     clk_2,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic [3:0]               msg_len,
    input  logic [MAX_LEN*SYM_W-1:0] msg,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               pos,
    output logic [7:0]               SEG
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'((GAP_TICKS != 0) ? GAP_TICKS - 1 : 0);

    state_t                   r_state, w_state_d;
    logic [TICK_W-1:0]        r_tick, w_tick_d;
    logic [GAP_W-1:0]         r_gap, w_gap_d;
    logic [2:0]               r_pos, w_pos_d;
    logic [3:0]               r_len, w_len_d;
    logic [MAX_LEN*SYM_W-1:0] r_msg, w_msg_d;
    logic [7:0]               r_seg, w_seg_d;
    logic                     r_busy, r_done, w_done_d;

    logic [3:0] w_len_in;
    logic       w_period_end;
    logic       w_last;
    logic       w_dp;
    sym_t       w_sym;
    logic [6:0] w_dec;

    assign w_len_in     = (msg_len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : msg_len;
    assign w_period_end = (r_tick == TICK_MAX);
    assign w_last       = ({1'b0, r_pos} == (r_len - 4'd1));

    always_comb begin
        w_state_d = r_state;
        w_tick_d  = r_tick + 1'b1;
        w_gap_d   = r_gap;
        w_pos_d   = r_pos;
        w_len_d   = r_len;
        w_msg_d   = r_msg;
        w_done_d  = 1'b0;
        case (r_state)
            IDLE: begin
                w_tick_d = '0;
                w_gap_d  = '0;
                w_pos_d  = '0;
                // stop blocks a simultaneous start, including the empty-message done
                if (start && !stop) begin
                    w_msg_d = msg;
                    w_len_d = w_len_in;
                    if (w_len_in == 4'd0) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_state_d = SHOW;
                    end
                end
            end
            SHOW: begin
                if (stop) begin
                    w_state_d = IDLE;
                    w_tick_d  = '0;
                    w_pos_d   = '0;
                end else if (w_period_end) begin
                    w_tick_d = '0;
                    w_gap_d  = '0;
                    // pos moves to the pending symbol before the gap starts
                    w_pos_d  = w_last ? 3'd0 : r_pos + 3'd1;
                    if (w_last && !loop_en) begin
                        w_state_d = IDLE;
                        w_done_d  = 1'b1;
                    end else if (GAP_TICKS != 0) begin
                        w_state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (stop) begin
                    w_state_d = IDLE;
                    w_tick_d  = '0;
                    w_gap_d   = '0;
                    w_pos_d   = '0;
                end else if (w_period_end) begin
                    w_tick_d = '0;
                    if (r_gap == GAP_MAX) begin
                        w_state_d = SHOW;
                        w_gap_d   = '0;
                    end else begin
                        w_gap_d = r_gap + 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
                w_tick_d  = '0;
            end
        endcase
    end

    assign w_sym = sym_t'(w_msg_d[w_pos_d*SYM_W +: SYM_W]);

    seg7_symbol_decoder u_decoder (
        .i_sym (w_sym),
        .o_seg (w_dec)
    );

`ifdef SEG7_MSG_DP_EN
    assign w_dp = ({1'b0, w_pos_d} == (w_len_d - 4'd1));
`else
    assign w_dp = 1'b0;
`endif

    assign w_seg_d = (w_state_d == SHOW) ? {w_dp, w_dec} : 8'h00;

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_gap   <= '0;
            r_pos   <= '0;
            r_len   <= '0;
            r_msg   <= '0;
            r_seg   <= 8'h00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_tick  <= w_tick_d;
            r_gap   <= w_gap_d;
            r_pos   <= w_pos_d;
            r_len   <= w_len_d;
            r_msg   <= w_msg_d;
            r_seg   <= w_seg_d;
            r_busy  <= (w_state_d != IDLE);
            r_done  <= w_done_d;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign pos  = r_pos;
    assign SEG  = r_seg;

endmodule

// File: tb/tb_seg7_msg_sequencer.sv
// Scoreboard bench: dut0 without gap, dut1 with one blank gap period, both TICK_DIV=4.
module tb_seg7_msg_sequencer;

`ifdef SEG7_MSG_DP_EN
    localparam logic DP_ON = 1'b1;
`else
    localparam logic DP_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0] seg;
        logic       busy;
        logic       done;
        logic [2:0] pos;
        string      tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1, stop, loop_en;
    logic [3:0]  msg_len;
    logic [47:0] msg;
    logic        busy0, done0, busy1, done1;
    logic [2:0]  pos0, pos1;
    logic [7:0]  seg0, seg1;

    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    seg7_msg_sequencer #(.TICK_DIV(4), .GAP_TICKS(0), .MAX_LEN(8), .SYM_W(6)) dut0 (
        .clk_2(clk), .reset(rst), .start(start0), .stop(stop), .loop_en(loop_en),
        .msg_len(msg_len), .msg(msg), .busy(busy0), .done(done0), .pos(pos0), .SEG(seg0)
    );

    seg7_msg_sequencer #(.TICK_DIV(4), .GAP_TICKS(1), .MAX_LEN(8), .SYM_W(6)) dut1 (
        .clk_2(clk), .reset(rst), .start(start1), .stop(stop), .loop_en(loop_en),
        .msg_len(msg_len), .msg(msg), .busy(busy1), .done(done1), .pos(pos1), .SEG(seg1)
    );

    function automatic logic [47:0] pk(input logic [5:0] a, b, c, d, e, f, g, h);
        return {h, g, f, e, d, c, b, a};
    endfunction

    function automatic logic [7:0] lst(input logic [6:0] p);
        return {DP_ON, p};
    endfunction

    function automatic void push(input int d, input logic [7:0] s, input logic b,
                                 input logic dn, input logic [2:0] p, input int n,
                                 input string tag);
        exp_t e;
        e.seg = s; e.busy = b; e.done = dn; e.pos = p; e.tag = tag;
        for (int i = 0; i < n; i++) begin
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endfunction

    task automatic cmp(input int d, input exp_t e, input logic [7:0] s, input logic b,
                       input logic dn, input logic [2:0] p);
        checks++;
        if (s !== e.seg || b !== e.busy || dn !== e.done || p !== e.pos) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got seg=%h busy=%b done=%b pos=%0d, want seg=%h busy=%b done=%b pos=%0d",
                     e.tag, d, $time, s, b, dn, p, e.seg, e.busy, e.done, e.pos);
        end
    endtask

    // Monitor: one expected record per DUT per cycle while its queue holds entries
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                cmp(0, e, seg0, busy0, done0, pos0);
            end
            if (q1.size() != 0) begin
                e = q1.pop_front();
                cmp(1, e, seg1, busy1, done1, pos1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All stimulus tasks begin and end 1 time unit after a rising edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int  k = 0;
        bit  waited = 0;
        while ((q0.size() != 0 || q1.size() != 0) && k < 500) begin
            @(posedge clk);
            k++;
            waited = 1;
        end
        if (waited) #1;
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d/%0d pending records, want 0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic pulse_start(input int d);
        if (d == 0) start0 = 1'b1;
        else start1 = 1'b1;
        cyc(1);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    logic [6:0] pats8 [8];

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; stop = 1'b0; loop_en = 1'b0;
        msg_len = 4'd0; msg = '0;
        cyc(1);
        push(0, 8'h00, 0, 0, 0, 3, "reset_state");
        push(1, 8'h00, 0, 0, 0, 3, "reset_state");
        cyc(2);
        rst = 1'b0;
        drain();

        // Three symbols, no gap
        msg = pk(1, 10, 15, 0, 0, 0, 0, 0); msg_len = 4'd3;
        push(0, 8'h00, 0, 0, 0, 1, "t1_pre");
        push(0, 8'h06, 1, 0, 0, 4, "t1_sym0");
        push(0, 8'h77, 1, 0, 1, 4, "t1_sym1");
        push(0, lst(7'h71), 1, 0, 2, 4, "t1_sym2");
        push(0, 8'h00, 0, 1, 0, 1, "t1_done");
        push(0, 8'h00, 0, 0, 0, 2, "t1_post");
        pulse_start(0);
        drain();

        // Two symbols with one blank gap period
        msg = pk(16, 41, 0, 0, 0, 0, 0, 0); msg_len = 4'd2;
        push(1, 8'h00, 0, 0, 0, 1, "t2_pre");
        push(1, 8'h77, 1, 0, 0, 4, "t2_sym0");
        push(1, 8'h00, 1, 0, 1, 4, "t2_gap");
        push(1, lst(7'h63), 1, 0, 1, 4, "t2_sym1");
        push(1, 8'h00, 0, 1, 0, 1, "t2_done");
        push(1, 8'h00, 0, 0, 0, 2, "t2_post");
        pulse_start(1);
        drain();

        // Loop, then drop loop_en part way through the second pass
        msg = pk(0, 8, 0, 0, 0, 0, 0, 0); msg_len = 4'd2; loop_en = 1'b1;
        push(0, 8'h00, 0, 0, 0, 1, "t3_pre");
        push(0, 8'h3f, 1, 0, 0, 4, "t3_p1s0");
        push(0, lst(7'h7f), 1, 0, 1, 4, "t3_p1s1");
        push(0, 8'h3f, 1, 0, 0, 4, "t3_p2s0");
        push(0, lst(7'h7f), 1, 0, 1, 4, "t3_p2s1");
        push(0, 8'h00, 0, 1, 0, 1, "t3_done");
        push(0, 8'h00, 0, 0, 0, 2, "t3_post");
        pulse_start(0);
        cyc(10);
        loop_en = 1'b0;
        drain();

        // Start while busy is ignored; stop in cycle 6 aborts without done
        msg = pk(2, 3, 4, 0, 0, 0, 0, 0); msg_len = 4'd3;
        push(0, 8'h00, 0, 0, 0, 1, "t4_pre");
        push(0, 8'h5b, 1, 0, 0, 4, "t4_sym0");
        push(0, 8'h4f, 1, 0, 1, 2, "t4_sym1");
        push(0, 8'h00, 0, 0, 0, 4, "t4_stopped");
        pulse_start(0);
        cyc(2);
        msg = pk(9, 9, 9, 0, 0, 0, 0, 0); msg_len = 4'd1;
        pulse_start(0);
        cyc(2);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        drain();

        // stop and start together while idle
        msg = pk(1, 0, 0, 0, 0, 0, 0, 0); msg_len = 4'd1; stop = 1'b1;
        push(1, 8'h00, 0, 0, 0, 5, "t5_startstop");
        pulse_start(1);
        stop = 1'b0;
        drain();

        // Empty message
        msg_len = 4'd0;
        push(1, 8'h00, 0, 0, 0, 1, "t6_pre");
        push(1, 8'h00, 0, 1, 0, 1, "t6_done");
        push(1, 8'h00, 0, 0, 0, 3, "t6_post");
        pulse_start(1);
        drain();

        // Length 12 clamps to 8
        pats8 = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07};
        msg = pk(0, 1, 2, 3, 4, 5, 6, 7); msg_len = 4'd12;
        push(0, 8'h00, 0, 0, 0, 1, "t7_pre");
        for (int i = 0; i < 8; i++)
            push(0, (i == 7) ? lst(pats8[i]) : {1'b0, pats8[i]}, 1, 0, 3'(i), 4, "t7_sym");
        push(0, 8'h00, 0, 1, 0, 1, "t7_done");
        push(0, 8'h00, 0, 0, 0, 2, "t7_post");
        pulse_start(0);
        drain();

        // Symbol 50 decodes to blank but still occupies a period
        msg = pk(50, 0, 0, 0, 0, 0, 0, 0); msg_len = 4'd1;
        push(0, 8'h00, 0, 0, 0, 1, "t8_pre");
        push(0, lst(7'h00), 1, 0, 0, 4, "t8_blank");
        push(0, 8'h00, 0, 1, 0, 1, "t8_done");
        push(0, 8'h00, 0, 0, 0, 2, "t8_post");
        pulse_start(0);
        drain();

        // Asynchronous reset in the middle of a SHOW period
        msg = pk(5, 6, 0, 0, 0, 0, 0, 0); msg_len = 4'd2;
        push(0, 8'h00, 0, 0, 0, 1, "t9_pre");
        push(0, 8'h6d, 1, 0, 0, 2, "t9_sym0");
        push(0, 8'h00, 0, 0, 0, 6, "t9_reset");
        pulse_start(0);
        cyc(2);
        rst = 1'b1;
        #1;
        checks++;
        if (seg0 !== 8'h00 || busy0 !== 1'b0 || pos0 !== 3'd0) begin
            errors++;
            $display("FAIL t9_async: got seg=%h busy=%b pos=%0d, want seg=00 busy=0 pos=0",
                     seg0, busy0, pos0);
        end
        cyc(2);
        rst = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
